pcs_tx_ordered_set: RTL and testbench

- Transmit ordered-set state machine of the 1000BASE-X PCS, per the IEEE 802.3 cl.36 transmit ordered-set process (simplified).
- Takes GMII TX_EN/TX_ER/TXD from the MAC and tells the downstream code-group encoder which ordered set to send.
- Produces `transmitting`, which feeds the carrier-sense block directly (together with `receiving` and `repeater_mode`).
- xmit is fixed at DATA; no configuration or test-pattern modes.

---
 rtl/pcs_tx_ordered_set.sv | 153 +++++++++++++++
 tb/tb_pcs_tx_ordered_set.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set FSM (xmit=DATA only): maps GMII TX_EN/TX_ER/TXD
// onto the ordered set the code-group encoder sends next, plus the transmitting flag for CRS.
module pcs_tx_ordered_set #(
  parameter int unsigned DW = 8
) (
  input  logic          CLOCK,
  input  logic          mr_main_reset,
  input  logic          TX_EN,
  input  logic          TX_ER,
  input  logic [DW-1:0] TXD,
  input  logic          cg_done,
  input  logic          tx_even,
  output logic [2:0]    tx_o_set,
  output logic [DW-1:0] tx_data,
  output logic          transmitting
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SOP       = 4'd1,
    ST_DATA      = 4'd2,
    ST_EOP_NOEXT = 4'd3,
    ST_EPD2      = 4'd4,
    ST_EPD3      = 4'd5,
    ST_EOP_EXT   = 4'd6,
    ST_CAR_EXT   = 4'd7,
    ST_EXT_BY_1  = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    OS_I = 3'd0,
    OS_S = 3'd1,
    OS_D = 3'd2,
    OS_T = 3'd3,
    OS_R = 3'd4,
    OS_V = 3'd5
  } oset_e;

  localparam logic [DW-1:0] CEXT_OCTET = DW'(8'h0F);

  state_e        state_q, state_d;
  oset_e         oset_q,  oset_d;
  logic [DW-1:0] data_q,  data_d;
  logic          xmit_q,  xmit_d;

  always_ff @(posedge CLOCK) begin
    if (!mr_main_reset) begin
      state_q <= ST_IDLE;
      oset_q  <= OS_I;
      data_q  <= '0;
      xmit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      oset_q  <= oset_d;
      data_q  <= data_d;
      xmit_q  <= xmit_d;
    end
  end

  // Outputs are computed for the state being entered so they register alongside it.
  always_comb begin
    state_d = state_q;
    oset_d  = oset_q;
    data_d  = data_q;
    xmit_d  = xmit_q;
    if (cg_done) begin
      case (state_q)
        ST_IDLE: begin
          if (TX_EN && !TX_ER) begin
            state_d = ST_SOP;
            oset_d  = OS_S;
            xmit_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            oset_d  = OS_I;
            xmit_d  = 1'b0;
          end
        end
        ST_SOP: begin
          state_d = ST_DATA;
          oset_d  = OS_D;
          xmit_d  = 1'b1;
        end
        ST_DATA: begin
          if (TX_EN) begin
            state_d = ST_DATA;
            xmit_d  = 1'b1;
            if (TX_ER) begin
              oset_d = OS_V;
            end else begin
              oset_d = OS_D;
              data_d = TXD;
            end
          end else if (TX_ER) begin
            state_d = ST_EOP_EXT;
            oset_d  = OS_T;
            xmit_d  = 1'b1;
          end else begin
            state_d = ST_EOP_NOEXT;
            oset_d  = OS_T;
            xmit_d  = 1'b0;
          end
        end
        ST_EOP_NOEXT, ST_EXT_BY_1: begin
          state_d = ST_EPD2;
          oset_d  = OS_R;
          xmit_d  = 1'b0;
        end
        ST_EPD2: begin
          if (tx_even) begin
            state_d = ST_IDLE;
            oset_d  = OS_I;
          end else begin
            state_d = ST_EPD3;
            oset_d  = OS_R;
          end
          xmit_d = 1'b0;
        end
        ST_EPD3: begin
          state_d = ST_IDLE;
          oset_d  = OS_I;
          xmit_d  = 1'b0;
        end
        ST_EOP_EXT, ST_CAR_EXT: begin
          if (TX_EN) begin
            state_d = ST_SOP;
            oset_d  = OS_S;
            xmit_d  = 1'b1;
          end else if (TX_ER) begin
            // Carrier extension carries /V/ when the MAC signals an extension error.
            state_d = ST_CAR_EXT;
            oset_d  = (TXD == CEXT_OCTET) ? OS_R : OS_V;
            xmit_d  = 1'b1;
          end else begin
            state_d = ST_EXT_BY_1;
            oset_d  = OS_R;
            xmit_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          oset_d  = OS_I;
          xmit_d  = 1'b0;
        end
      endcase
    end
  end

  assign tx_o_set     = oset_q;
  assign tx_data      = data_q;
  assign transmitting = xmit_q;

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// Directed bench for pcs_tx_ordered_set: per-scenario vector tables with hand-computed
// expected ordered sets, transmitting flag and tx_data after each rising edge.
module tb_pcs_tx_ordered_set;

  logic       CLOCK = 1'b0;
  logic       mr_main_reset;
  logic       TX_EN;
  logic       TX_ER;
  logic [7:0] TXD;
  logic       cg_done;
  logic       tx_even;
  logic [2:0] tx_o_set;
  logic [7:0] tx_data;
  logic       transmitting;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] I = 3'd0, S = 3'd1, D = 3'd2, T = 3'd3, R = 3'd4, V = 3'd5;

  typedef struct {
    logic       rst;
    logic       en;
    logic       er;
    logic [7:0] d;
    logic       cg;
    logic       ev;
    logic [2:0] os;
    logic       tr;
    logic [7:0] dat;
  } vec_t;

  pcs_tx_ordered_set #(.DW(8)) dut (
    .CLOCK        (CLOCK),
    .mr_main_reset(mr_main_reset),
    .TX_EN        (TX_EN),
    .TX_ER        (TX_ER),
    .TXD          (TXD),
    .cg_done      (cg_done),
    .tx_even      (tx_even),
    .tx_o_set     (tx_o_set),
    .tx_data      (tx_data),
    .transmitting (transmitting)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic vec_t mk(input logic rst, input logic en, input logic er,
                              input logic [7:0] d, input logic cg, input logic ev,
                              input logic [2:0] os, input logic tr, input logic [7:0] dat);
    vec_t v;
    v.rst = rst; v.en = en; v.er = er; v.d = d; v.cg = cg; v.ev = ev;
    v.os = os; v.tr = tr; v.dat = dat;
    return v;
  endfunction

  // Drive one vector, let one rising edge pass, then settle before sampling.
  task automatic apply(input vec_t v);
    mr_main_reset = v.rst;
    TX_EN         = v.en;
    TX_ER         = v.er;
    TXD           = v.d;
    cg_done       = v.cg;
    tx_even       = v.ev;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    vec_t q[$];
    for (int unsigned k = 0; k < 3; k++) q.push_back(mk(0, 1, 0, 8'hA5, 1, 1, I, 0, 8'h00));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (tx_o_set !== q[i].os || transmitting !== q[i].tr || tx_data !== q[i].dat) begin
        bad++;
        $display("FAIL reset[%0d]: got oset=%0d tr=%b data=%h, want oset=%0d tr=%b data=%h",
                 i, tx_o_set, transmitting, tx_data, q[i].os, q[i].tr, q[i].dat);
      end
    end
  endtask

  task automatic test_plain_frame();
    vec_t q[$];
    q.push_back(mk(1, 0, 0, 8'h00, 1, 0, I, 0, 8'h00));
    q.push_back(mk(1, 1, 0, 8'h55, 1, 0, S, 1, 8'h00));
    q.push_back(mk(1, 1, 0, 8'h55, 1, 0, D, 1, 8'h00));
    q.push_back(mk(1, 1, 0, 8'hD5, 1, 0, D, 1, 8'hD5));
    q.push_back(mk(1, 1, 0, 8'hAB, 1, 0, D, 1, 8'hAB));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 0, T, 0, 8'hAB));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 0, R, 0, 8'hAB));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 1, I, 0, 8'hAB));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (tx_o_set !== q[i].os || transmitting !== q[i].tr || tx_data !== q[i].dat) begin
        bad++;
        $display("FAIL plain[%0d]: got oset=%0d tr=%b data=%h, want oset=%0d tr=%b data=%h",
                 i, tx_o_set, transmitting, tx_data, q[i].os, q[i].tr, q[i].dat);
      end
    end
  endtask

  task automatic test_odd_end();
    vec_t q[$];
    q.push_back(mk(1, 1, 0, 8'h55, 1, 0, S, 1, 8'hAB));
    q.push_back(mk(1, 1, 0, 8'h55, 1, 0, D, 1, 8'hAB));
    q.push_back(mk(1, 1, 0, 8'hD5, 1, 0, D, 1, 8'hD5));
    q.push_back(mk(1, 1, 0, 8'hAB, 1, 0, D, 1, 8'hAB));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 0, T, 0, 8'hAB));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 0, R, 0, 8'hAB));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 0, R, 0, 8'hAB));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 1, I, 0, 8'hAB));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (tx_o_set !== q[i].os || transmitting !== q[i].tr || tx_data !== q[i].dat) begin
        bad++;
        $display("FAIL odd_end[%0d]: got oset=%0d tr=%b data=%h, want oset=%0d tr=%b data=%h",
                 i, tx_o_set, transmitting, tx_data, q[i].os, q[i].tr, q[i].dat);
      end
    end
  endtask

  task automatic test_error_extension();
    vec_t q[$];
    q.push_back(mk(1, 1, 0, 8'h00, 1, 0, S, 1, 8'hAB));
    q.push_back(mk(1, 1, 0, 8'h00, 1, 0, D, 1, 8'hAB));
    q.push_back(mk(1, 1, 0, 8'h11, 1, 0, D, 1, 8'h11));
    q.push_back(mk(1, 1, 1, 8'h22, 1, 0, V, 1, 8'h11));
    q.push_back(mk(1, 0, 1, 8'h0F, 1, 0, T, 1, 8'h11));
    q.push_back(mk(1, 0, 1, 8'h0F, 1, 0, R, 1, 8'h11));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 0, R, 0, 8'h11));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 0, R, 0, 8'h11));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 1, I, 0, 8'h11));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (tx_o_set !== q[i].os || transmitting !== q[i].tr || tx_data !== q[i].dat) begin
        bad++;
        $display("FAIL err_ext[%0d]: got oset=%0d tr=%b data=%h, want oset=%0d tr=%b data=%h",
                 i, tx_o_set, transmitting, tx_data, q[i].os, q[i].tr, q[i].dat);
      end
    end
  endtask

  task automatic test_back_pressure();
    vec_t q[$];
    q.push_back(mk(1, 1, 0, 8'h00, 1, 0, S, 1, 8'h11));
    q.push_back(mk(1, 1, 0, 8'h00, 1, 0, D, 1, 8'h11));
    q.push_back(mk(1, 1, 0, 8'h33, 1, 0, D, 1, 8'h33));
    for (int unsigned k = 0; k < 5; k++)
      q.push_back(mk(1, k[0], 1, 8'h40 + 8'(k), 0, 1, D, 1, 8'h33));
    q.push_back(mk(1, 1, 0, 8'h44, 1, 0, D, 1, 8'h44));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 0, T, 0, 8'h44));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 0, R, 0, 8'h44));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 1, I, 0, 8'h44));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (tx_o_set !== q[i].os || transmitting !== q[i].tr || tx_data !== q[i].dat) begin
        bad++;
        $display("FAIL backpress[%0d]: got oset=%0d tr=%b data=%h, want oset=%0d tr=%b data=%h",
                 i, tx_o_set, transmitting, tx_data, q[i].os, q[i].tr, q[i].dat);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t q[$];
    q.push_back(mk(1, 1, 0, 8'h00, 1, 0, S, 1, 8'h44));
    q.push_back(mk(1, 1, 0, 8'h00, 1, 0, D, 1, 8'h44));
    q.push_back(mk(1, 1, 0, 8'h55, 1, 0, D, 1, 8'h55));
    q.push_back(mk(1, 0, 1, 8'h1F, 1, 0, T, 1, 8'h55));
    q.push_back(mk(1, 0, 1, 8'h1F, 1, 0, V, 1, 8'h55));
    q.push_back(mk(1, 1, 1, 8'h00, 1, 0, S, 1, 8'h55));
    q.push_back(mk(1, 1, 0, 8'h00, 1, 0, D, 1, 8'h55));
    q.push_back(mk(1, 1, 0, 8'h77, 1, 0, D, 1, 8'h77));
    q.push_back(mk(0, 1, 0, 8'h88, 0, 0, I, 0, 8'h00));
    q.push_back(mk(1, 0, 0, 8'h00, 1, 0, I, 0, 8'h00));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (tx_o_set !== q[i].os || transmitting !== q[i].tr || tx_data !== q[i].dat) begin
        bad++;
        $display("FAIL burst_rst[%0d]: got oset=%0d tr=%b data=%h, want oset=%0d tr=%b data=%h",
                 i, tx_o_set, transmitting, tx_data, q[i].os, q[i].tr, q[i].dat);
      end
    end
  endtask

  initial begin
    mr_main_reset = 1'b0;
    TX_EN         = 1'b0;
    TX_ER         = 1'b0;
    TXD           = 8'h00;
    cg_done       = 1'b1;
    tx_even       = 1'b0;
    test_reset();
    test_plain_frame();
    test_odd_end();
    test_error_extension();
    test_back_pressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
